axi_if_ucore_rd_arb: RTL and testbench

Two-requester read arbiter and burst sequencer for the ucore AXI4 read channel (32-bit address, 32-bit data, 1-bit ID). It accepts word-granular read commands from two local clients (IOp fetch = requester 0, DOp translation = requester 1). Commands are granted round-robin. Each command is split into INCR bursts that never cross a PAGE_BYTES boundary and never exceed AXI4_LEN_MAX+1 beats. Read data is returned to the owning client. One burst is outstanding at a time.

---
 rtl/axi_if_ucore_rd_arb.sv | 215 +++++++++++++++++++++
 tb/tb_axi_if_ucore_rd_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_if_ucore_rd_arb.sv
// -----------------------------------------------------------------------------
// axi_if_ucore_rd_arb
//
// Two-requester read arbiter and burst sequencer for the ucore AXI4 read
// channel. Word-granular read commands from requester 0 (IOp fetch) and
// requester 1 (DOp translation) are granted round-robin. Each command is cut
// into INCR bursts that never cross a PAGE_BYTES boundary and never exceed
// min(PAGE_BYTES/4, 256) beats. Read data is returned combinationally to the
// owning requester. Only one burst is outstanding at a time.
//
// Optional feature macro: AXI_IF_UCORE_RD_ARB_RESP_CHECK_EN
//   defined     : rspN_err flags beats with rresp != OKAY, 'error' is sticky.
//   not defined : rspN_err and error are tied low, rresp is ignored.
//
// Ports
//   clk, s_rst                     clock, synchronous active-high reset
//   reqN_vld/rdy/add/nword         command handshake (N = 0, 1)
//   rspN_vld/rdy/data/last/err     read word return (N = 0, 1)
//   m_axi4_ar*                     AXI4 read address channel (master)
//   m_axi4_r*                      AXI4 read data channel (master)
//   error                          sticky response error flag
// -----------------------------------------------------------------------------
module axi_if_ucore_rd_arb #(
    parameter int unsigned PAGE_BYTES = 4096,
    parameter int unsigned NWORD_W    = 16
) (
    input  logic               clk,
    input  logic               s_rst,
    input  logic               req0_vld,
    output logic               req0_rdy,
    input  logic [31:0]        req0_add,
    input  logic [NWORD_W-1:0] req0_nword,
    input  logic               req1_vld,
    output logic               req1_rdy,
    input  logic [31:0]        req1_add,
    input  logic [NWORD_W-1:0] req1_nword,
    output logic               rsp0_vld,
    input  logic               rsp0_rdy,
    output logic [31:0]        rsp0_data,
    output logic               rsp0_last,
    output logic               rsp0_err,
    output logic               rsp1_vld,
    input  logic               rsp1_rdy,
    output logic [31:0]        rsp1_data,
    output logic               rsp1_last,
    output logic               rsp1_err,
    output logic               m_axi4_arid,
    output logic [31:0]        m_axi4_araddr,
    output logic [7:0]         m_axi4_arlen,
    output logic [2:0]         m_axi4_arsize,
    output logic [1:0]         m_axi4_arburst,
    output logic               m_axi4_arvalid,
    input  logic               m_axi4_arready,
    input  logic               m_axi4_rid,
    input  logic [31:0]        m_axi4_rdata,
    input  logic [1:0]         m_axi4_rresp,
    input  logic               m_axi4_rlast,
    input  logic               m_axi4_rvalid,
    output logic               m_axi4_rready,
    output logic               error
);

    localparam int unsigned PAGE_WORDS = PAGE_BYTES / 4;
    localparam int unsigned MAX_BEATS  = (PAGE_WORDS < 256) ? PAGE_WORDS : 256;
    localparam int unsigned PAGE_AW    = $clog2(PAGE_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB_AR = 2'd1,
        RDATA  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;  // requester granted most recently
    logic               owner_q, owner_d;
    logic [31:0]        addr_q, addr_d;
    logic [NWORD_W-1:0] rem_q, rem_d;            // words not yet requested on AR
    logic [7:0]         arlen_q, arlen_d;
    logic               arvalid_q, arvalid_d;

    logic               pick1;
    logic               in_rdata;
    logic               r_last_hs;
    logic [8:0]         beats;
    logic [31:0]        page_words;
    logic [31:0]        beats_w;

    // With both requesters valid, the one not granted last wins.
    assign pick1    = (req0_vld && req1_vld) ? ~last_gnt_q : req1_vld;
    assign req0_rdy = (state_q == IDLE) && !s_rst && req0_vld && !pick1;
    assign req1_rdy = (state_q == IDLE) && !s_rst && req1_vld && pick1;

    // Burst sizing works on registered address/remaining, so it runs in the
    // first ARB_AR cycle and arvalid follows one cycle later.
    always_comb begin
        page_words = (32'(PAGE_BYTES) - 32'(addr_q[PAGE_AW-1:0])) >> 2;
        beats_w    = 32'(rem_q);
        if (page_words < beats_w) beats_w = page_words;
        if (32'(MAX_BEATS) < beats_w) beats_w = 32'(MAX_BEATS);
    end

    assign beats     = {1'b0, arlen_q} + 9'd1;
    assign in_rdata  = (state_q == RDATA);
    assign r_last_hs = m_axi4_rvalid && m_axi4_rready && m_axi4_rlast;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        arlen_d    = arlen_q;
        arvalid_d  = arvalid_q;
        unique case (state_q)
            IDLE: begin
                if (req0_vld || req1_vld) begin
                    owner_d    = pick1;
                    last_gnt_d = pick1;
                    addr_d     = pick1 ? req1_add : req0_add;
                    rem_d      = pick1 ? req1_nword : req0_nword;
                    state_d    = ARB_AR;
                end
            end
            ARB_AR: begin
                if (!arvalid_q) begin
                    arlen_d   = 8'(beats_w - 32'd1);
                    arvalid_d = 1'b1;
                end else if (m_axi4_arready) begin
                    arvalid_d = 1'b0;
                    addr_d    = addr_q + {21'd0, beats, 2'b00};
                    rem_d     = rem_q - NWORD_W'(beats);
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (r_last_hs) state_d = (rem_q == '0) ? IDLE : ARB_AR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (s_rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            arlen_q    <= '0;
            arvalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            arlen_q    <= arlen_d;
            arvalid_q  <= arvalid_d;
        end
    end

    assign m_axi4_arid    = owner_q;
    assign m_axi4_araddr  = addr_q;
    assign m_axi4_arlen   = arlen_q;
    assign m_axi4_arsize  = 3'd2;
    assign m_axi4_arburst = 2'b01;
    assign m_axi4_arvalid = arvalid_q;

    // R is routed by owner only; rid is checked by assertion, not used.
    assign rsp0_vld      = in_rdata && m_axi4_rvalid && !owner_q;
    assign rsp1_vld      = in_rdata && m_axi4_rvalid && owner_q;
    assign m_axi4_rready = in_rdata && (owner_q ? rsp1_rdy : rsp0_rdy);
    assign rsp0_data     = m_axi4_rdata;
    assign rsp1_data     = m_axi4_rdata;
    // rem_q already excludes the current burst, so zero marks the final one.
    assign rsp0_last     = m_axi4_rlast && (rem_q == '0);
    assign rsp1_last     = m_axi4_rlast && (rem_q == '0);

`ifdef AXI_IF_UCORE_RD_ARB_RESP_CHECK_EN
    logic resp_bad;
    logic error_q;

    assign resp_bad = (m_axi4_rresp != 2'b00);
    assign rsp0_err = rsp0_vld && resp_bad;
    assign rsp1_err = rsp1_vld && resp_bad;

    always_ff @(posedge clk) begin
        if (s_rst) error_q <= 1'b0;
        else if (rsp0_err || rsp1_err) error_q <= 1'b1;
    end
    assign error = error_q;
`else
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
    assign error    = 1'b0;
`endif

    // Inputs that carry no routing information in this block.
    logic unused_in;
    assign unused_in = ^{m_axi4_rid, m_axi4_rresp};

    // Returned ID must belong to the current owner.
    a_rid_owner: assert property (@(posedge clk) disable iff (s_rst)
        (in_rdata && m_axi4_rvalid) |-> (m_axi4_rid == owner_q));

    // A command must not run past the top of the 32-bit address space.
    a_no_addr_wrap: assert property (@(posedge clk) disable iff (s_rst)
        (arvalid_q && m_axi4_arready && rem_d != '0)
        |-> !(({1'b0, addr_q} + {22'd0, beats, 2'b00}) > 33'h0_FFFF_FFFF));

endmodule

// File: tb/tb_axi_if_ucore_rd_arb.sv
// -----------------------------------------------------------------------------
// tb_axi_if_ucore_rd_arb
//
// Scoreboard bench: when a command is accepted, the expected AR bursts and
// read words are pushed to queues; they are popped and compared when the DUT
// issues AR handshakes and returns words. An AXI slave model answers each
// burst with address-derived data. Honours AXI_IF_UCORE_RD_ARB_RESP_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_axi_if_ucore_rd_arb;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned NWORD_W    = 16;
    localparam int unsigned MAX_BEATS  = 256;
`ifdef AXI_IF_UCORE_RD_ARB_RESP_CHECK_EN
    localparam bit RESP_CHK = 1'b1;
`else
    localparam bit RESP_CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        id;
    } ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } word_t;

    typedef struct packed {
        logic [31:0] add;
        logic [15:0] nword;
    } cmd_t;

    logic clk = 1'b0;
    logic s_rst;
    logic req0_vld, req0_rdy, req1_vld, req1_rdy;
    logic [31:0] req0_add, req1_add;
    logic [NWORD_W-1:0] req0_nword, req1_nword;
    logic rsp0_vld, rsp0_rdy, rsp0_last, rsp0_err;
    logic rsp1_vld, rsp1_rdy, rsp1_last, rsp1_err;
    logic [31:0] rsp0_data, rsp1_data;
    logic m_axi4_arid, m_axi4_arvalid, m_axi4_arready;
    logic [31:0] m_axi4_araddr;
    logic [7:0] m_axi4_arlen;
    logic [2:0] m_axi4_arsize;
    logic [1:0] m_axi4_arburst;
    logic m_axi4_rid, m_axi4_rlast, m_axi4_rvalid, m_axi4_rready;
    logic [31:0] m_axi4_rdata;
    logic [1:0] m_axi4_rresp;
    logic error;

    always #5 clk = ~clk;

    axi_if_ucore_rd_arb #(.PAGE_BYTES(PAGE_BYTES), .NWORD_W(NWORD_W)) dut (
        .clk(clk), .s_rst(s_rst),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_add(req0_add), .req0_nword(req0_nword),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_add(req1_add), .req1_nword(req1_nword),
        .rsp0_vld(rsp0_vld), .rsp0_rdy(rsp0_rdy), .rsp0_data(rsp0_data), .rsp0_last(rsp0_last), .rsp0_err(rsp0_err),
        .rsp1_vld(rsp1_vld), .rsp1_rdy(rsp1_rdy), .rsp1_data(rsp1_data), .rsp1_last(rsp1_last), .rsp1_err(rsp1_err),
        .m_axi4_arid(m_axi4_arid), .m_axi4_araddr(m_axi4_araddr), .m_axi4_arlen(m_axi4_arlen),
        .m_axi4_arsize(m_axi4_arsize), .m_axi4_arburst(m_axi4_arburst),
        .m_axi4_arvalid(m_axi4_arvalid), .m_axi4_arready(m_axi4_arready),
        .m_axi4_rid(m_axi4_rid), .m_axi4_rdata(m_axi4_rdata), .m_axi4_rresp(m_axi4_rresp),
        .m_axi4_rlast(m_axi4_rlast), .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_rready(m_axi4_rready),
        .error(error)
    );

    // Scoreboard and stimulus state
    ar_t   exp_ar_q[$];
    word_t exp_w0[$];
    word_t exp_w1[$];
    cmd_t  cmd0[$];
    cmd_t  cmd1[$];
    ar_t   burst_q[$];
    int    grants[$];
    int    beat_idx   = 0;
    int    n_checks   = 0;
    int    n_errors   = 0;
    int    cyc        = 0;
    int    ar_due     = -1;
    int    rdy_due    = -1;
    int    ar_delay   = 0;
    int    ar_wait    = 0;
    bit    rdy0_toggle = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit    exp_error  = 1'b0;
    bit    req0_hs_f, req1_hs_f, ar_hs_f, r_hs_f;
    bit    ar_prev    = 1'b0;
    ar_t   ar_hold;
    int    route_bad  = 0;
    int    stable_bad = 0;
    int    mirror_bad = 0;
    int    errflag_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word_data(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Expected AR bursts and words for an accepted command.
    task automatic push_expected(input logic id, input logic [31:0] add, input int nword);
        logic [31:0] a;
        int unsigned rem, pw, b;
        word_t w;
        a   = add;
        rem = nword;
        while (rem > 0) begin
            pw = (PAGE_BYTES - (a % PAGE_BYTES)) / 4;
            b  = rem;
            if (pw < b) b = pw;
            if (MAX_BEATS < b) b = MAX_BEATS;
            exp_ar_q.push_back('{addr: a, len: 8'(b - 1), id: id});
            a   = a + 4 * b;
            rem = rem - b;
        end
        for (int i = 0; i < nword; i++) begin
            w.data = word_data(add + 32'(4 * i));
            w.last = (i == nword - 1);
            w.err  = RESP_CHK && ((add + 32'(4 * i)) == err_addr);
            if (id) exp_w1.push_back(w);
            else    exp_w0.push_back(w);
        end
    endtask

    // Monitor: samples mid-cycle, i.e. the values the next posedge captures.
    always @(negedge clk) begin
        word_t w;
        ar_t   e;
        logic  exp_rready;
        bit    cmd_done;
        cyc++;
        if (s_rst) begin
            req0_hs_f = 1'b0; req1_hs_f = 1'b0; ar_hs_f = 1'b0; r_hs_f = 1'b0;
            ar_prev = 1'b0; ar_due = -1; rdy_due = -1; exp_error = 1'b0; beat_idx = 0;
        end else begin
            cmd_done = 1'b0;
            // Command handshakes
            req0_hs_f = req0_vld && req0_rdy;
            req1_hs_f = req1_vld && req1_rdy;
            if (req0_rdy && req1_rdy) route_bad++;
            if (rdy_due == cyc) begin
                check("b2b_grant", {req0_rdy, req1_rdy} != 2'b00, 1'b1);
                rdy_due = -1;
            end
            if (req0_hs_f) begin grants.push_back(0); push_expected(1'b0, req0_add, int'(req0_nword)); ar_due = cyc + 2; end
            if (req1_hs_f) begin grants.push_back(1); push_expected(1'b1, req1_add, int'(req1_nword)); ar_due = cyc + 2; end

            // R side, evaluated against the burst currently outstanding
            exp_rready = 1'b0;
            if (burst_q.size() > 0) begin
                exp_rready = burst_q[0].id ? rsp1_rdy : rsp0_rdy;
                if (m_axi4_rvalid && ({rsp1_vld, rsp0_vld} != (burst_q[0].id ? 2'b10 : 2'b01))) route_bad++;
            end
            if (!m_axi4_rvalid && (rsp0_vld || rsp1_vld)) route_bad++;
            if (m_axi4_rready !== exp_rready) mirror_bad++;
            if (error !== exp_error) errflag_bad++;
            if (RESP_CHK && burst_q.size() > 0 && m_axi4_rvalid && m_axi4_rresp != 2'b00) exp_error = 1'b1;

            if (rsp0_vld && rsp0_rdy) begin
                if (exp_w0.size() == 0) check("rsp0_extra", 1'b1, 1'b0);
                else begin
                    w = exp_w0.pop_front();
                    check("rsp0_data", rsp0_data, w.data);
                    check("rsp0_last", rsp0_last, w.last);
                    check("rsp0_err", rsp0_err, w.err);
                    cmd_done = w.last;
                end
            end
            if (rsp1_vld && rsp1_rdy) begin
                if (exp_w1.size() == 0) check("rsp1_extra", 1'b1, 1'b0);
                else begin
                    w = exp_w1.pop_front();
                    check("rsp1_data", rsp1_data, w.data);
                    check("rsp1_last", rsp1_last, w.last);
                    check("rsp1_err", rsp1_err, w.err);
                    cmd_done = w.last;
                end
            end
            r_hs_f = m_axi4_rvalid && m_axi4_rready;
            if (r_hs_f && burst_q.size() > 0) begin
                if (m_axi4_rlast) begin
                    void'(burst_q.pop_front());
                    beat_idx = 0;
                    if (!cmd_done) ar_due = cyc + 2;
                    else if (req0_vld || req1_vld) rdy_due = cyc + 1;
                end else begin
                    beat_idx++;
                end
            end

            // AR side
            if (m_axi4_arvalid) begin
                if (!ar_prev) check("ar_latency", 32'(cyc), 32'(ar_due));
                else if ({m_axi4_araddr, m_axi4_arlen, m_axi4_arid} != ar_hold) stable_bad++;
                ar_hold = '{addr: m_axi4_araddr, len: m_axi4_arlen, id: m_axi4_arid};
            end else if (ar_prev) begin
                stable_bad++;
            end
            ar_prev = m_axi4_arvalid && !m_axi4_arready;
            ar_hs_f = m_axi4_arvalid && m_axi4_arready;
            if (ar_hs_f) begin
                if (exp_ar_q.size() == 0) check("ar_extra", 1'b1, 1'b0);
                else begin
                    e = exp_ar_q.pop_front();
                    check("araddr", m_axi4_araddr, e.addr);
                    check("arlen", m_axi4_arlen, e.len);
                    check("arid", m_axi4_arid, e.id);
                end
                burst_q.push_back('{addr: m_axi4_araddr, len: m_axi4_arlen, id: m_axi4_arid});
            end
        end
    end

    // Drivers: clients and AXI slave, updated just after each active edge.
    always @(posedge clk) begin
        logic [31:0] a;
        #1;
        if (req0_hs_f) void'(cmd0.pop_front());
        if (req1_hs_f) void'(cmd1.pop_front());
        req0_vld = (cmd0.size() > 0);
        req0_add = req0_vld ? cmd0[0].add : 32'd0;
        req0_nword = req0_vld ? cmd0[0].nword : '0;
        req1_vld = (cmd1.size() > 0);
        req1_add = req1_vld ? cmd1[0].add : 32'd0;
        req1_nword = req1_vld ? cmd1[0].nword : '0;
        rsp0_rdy = rdy0_toggle ? ~rsp0_rdy : 1'b1;
        rsp1_rdy = 1'b1;

        if (ar_hs_f || !m_axi4_arvalid) begin
            m_axi4_arready = 1'b0;
            ar_wait = 0;
        end else if (ar_wait >= ar_delay) begin
            m_axi4_arready = 1'b1;
        end else begin
            m_axi4_arready = 1'b0;
            ar_wait++;
        end

        if (burst_q.size() > 0) begin
            a = burst_q[0].addr + 32'(4 * beat_idx);
            m_axi4_rvalid = 1'b1;
            m_axi4_rid    = burst_q[0].id;
            m_axi4_rdata  = word_data(a);
            m_axi4_rlast  = (beat_idx == int'(burst_q[0].len));
            m_axi4_rresp  = (a == err_addr) ? 2'b10 : 2'b00;
        end else begin
            m_axi4_rvalid = 1'b0;
            m_axi4_rid    = 1'b0;
            m_axi4_rdata  = 32'd0;
            m_axi4_rlast  = 1'b0;
            m_axi4_rresp  = 2'b00;
        end
    end

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (n < max_cyc && !(cmd0.size() == 0 && cmd1.size() == 0 && exp_ar_q.size() == 0 &&
               exp_w0.size() == 0 && exp_w1.size() == 0 && burst_q.size() == 0)) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < max_cyc, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        s_rst = 1'b1;
        req0_vld = 1'b0; req0_add = '0; req0_nword = '0;
        req1_vld = 1'b0; req1_add = '0; req1_nword = '0;
        rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
        m_axi4_arready = 1'b0; m_axi4_rvalid = 1'b0; m_axi4_rid = 1'b0;
        m_axi4_rdata = '0; m_axi4_rlast = 1'b0; m_axi4_rresp = 2'b00;

        // Round-robin: both requesters valid straight out of reset.
        cmd0.push_back('{add: 32'h0000_3000, nword: 16'd2});
        cmd0.push_back('{add: 32'h0000_3010, nword: 16'd2});
        cmd1.push_back('{add: 32'h0000_5000, nword: 16'd2});
        cmd1.push_back('{add: 32'h0000_5010, nword: 16'd2});
        repeat (3) @(negedge clk);
        check("rst_req0_rdy", req0_rdy, 1'b0);
        check("rst_req1_rdy", req1_rdy, 1'b0);
        check("rst_arvalid", m_axi4_arvalid, 1'b0);
        check("rst_araddr", m_axi4_araddr, 32'd0);
        check("rst_arlen", m_axi4_arlen, 8'd0);
        check("rst_arid", m_axi4_arid, 1'b0);
        check("rst_rsp_vld", {rsp0_vld, rsp1_vld}, 2'b00);
        check("rst_rready", m_axi4_rready, 1'b0);
        check("rst_error", error, 1'b0);
        check("arsize", m_axi4_arsize, 3'd2);
        check("arburst", m_axi4_arburst, 2'b01);
        @(posedge clk); #1 s_rst = 1'b0;
        wait_done("rr_done", 500);
        check("rr_ngrants", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) check($sformatf("rr_grant%0d", i), grants[i], i % 2);

        // Single command, page split, length split
        cmd0.push_back('{add: 32'h0000_0000, nword: 16'd4});
        wait_done("single_done", 200);
        cmd1.push_back('{add: 32'h0000_0FF8, nword: 16'd6});
        wait_done("page_done", 200);
        cmd0.push_back('{add: 32'h0000_2000, nword: 16'd300});
        wait_done("len_done", 1000);
        cmd1.push_back('{add: 32'h0000_8000, nword: 16'd1});
        wait_done("one_word_done", 200);

        // Back-pressure on both AR and rsp0, across a page split
        rdy0_toggle = 1'b1;
        ar_delay = 5;
        cmd0.push_back('{add: 32'h0000_4FF0, nword: 16'd8});
        wait_done("bp_done", 500);
        rdy0_toggle = 1'b0;
        ar_delay = 0;

        // Error response on beat 2 of 4, then a clean command
        err_addr = 32'h0000_6004;
        cmd0.push_back('{add: 32'h0000_6000, nword: 16'd4});
        wait_done("err_done", 200);
        cmd0.push_back('{add: 32'h0000_7000, nword: 16'd2});
        wait_done("post_err_done", 200);
        check("error_sticky", error, RESP_CHK);
        err_addr = 32'hFFFF_FFFF;
        @(posedge clk); #1 s_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("error_cleared", error, 1'b0);
        @(posedge clk); #1 s_rst = 1'b0;
        repeat (2) @(negedge clk);

        check("route_violations", route_bad, 0);
        check("ar_stability", stable_bad, 0);
        check("rready_mirror", mirror_bad, 0);
        check("error_flag_track", errflag_bad, 0);
        check("exp_ar_left", exp_ar_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
